// File: rtl/axis_tx_fanout_ctrl.sv
// One-byte AXI-Stream broadcaster feeding a UART TX sink (0) and an ASK TX sink (1).
// Define FANOUT_TIMEOUT_EN to abandon sinks that stall longer than TIMEOUT_CYCLES.
module axis_tx_fanout_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_tdata,
   input  logic       i_tvalid,
   output logic       i_tready,
   output logic [7:0] o0_tdata,
   output logic       o0_tvalid,
   input  logic       o0_tready,
   output logic [7:0] o1_tdata,
   output logic       o1_tvalid,
   input  logic       o1_tready,
   input  logic [1:0] en,
   output logic       busy,
   output logic [1:0] err_timeout,
   input  logic       clr_err
);

   typedef enum logic {IDLE, BCAST} state_t;

   state_t     state_q, state_d;
   logic [1:0] pending_q, pending_d;
   logic [7:0] buf_q, buf_d;
   logic [1:0] hs;

   // Outputs are forced quiet while rst is high, even before the first reset edge.
   assign i_tready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q == BCAST) && !rst;
   assign o0_tvalid = pending_q[0] && !rst;
   assign o1_tvalid = pending_q[1] && !rst;
   assign o0_tdata  = buf_q;
   assign o1_tdata  = buf_q;
   assign hs        = {o1_tvalid & o1_tready, o0_tvalid & o0_tready};

`ifdef FANOUT_TIMEOUT_EN
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  err_q, err_d;

   assign err_timeout = err_q;
`else
   logic        unused_clr;
   logic [15:0] unused_timeout;

   assign unused_clr     = clr_err;
   assign unused_timeout = 16'(TIMEOUT_CYCLES);
   assign err_timeout    = 2'b00;
`endif

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path infers a latch.
      state_d   = state_q;
      pending_d = pending_q;
      buf_d     = buf_q;
`ifdef FANOUT_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q & ~{2{clr_err}};
`endif
      unique case (state_q)
         IDLE: begin
            if (i_tvalid && i_tready) begin
               buf_d     = i_tdata;
               pending_d = en;
`ifdef FANOUT_TIMEOUT_EN
               cnt_d     = '0;
`endif
               if (en != 2'b00) state_d = BCAST;
            end
         end
         BCAST: begin
            pending_d = pending_q & ~hs;
`ifdef FANOUT_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
            // A sink that handshakes on the expiry cycle has already been cleared above.
            if (cnt_q == CNT_LAST) begin
               err_d     = err_d | pending_d;
               pending_d = 2'b00;
            end
`endif
            if (pending_d == 2'b00) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 2'b00;
         buf_q     <= 8'h00;
`ifdef FANOUT_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 2'b00;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q   <= state_d;
         pending_q <= pending_d;
         buf_q     <= buf_d;
`ifdef FANOUT_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_axis_tx_fanout_ctrl.sv
// Directed bench for axis_tx_fanout_ctrl: broadcast, independent completion, drop, timeout, reset.
module tb_axis_tx_fanout_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_tdata;
   logic       i_tvalid;
   logic       i_tready;
   logic [7:0] o0_tdata, o1_tdata;
   logic       o0_tvalid, o1_tvalid;
   logic       o0_tready, o1_tready;
   logic [1:0] en;
   logic       busy;
   logic [1:0] err_timeout;
   logic       clr_err;

   int n_checks = 0;
   int n_errors = 0;

   axis_tx_fanout_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_tdata    (i_tdata),
      .i_tvalid   (i_tvalid),
      .i_tready   (i_tready),
      .o0_tdata   (o0_tdata),
      .o0_tvalid  (o0_tvalid),
      .o0_tready  (o0_tready),
      .o1_tdata   (o1_tdata),
      .o1_tvalid  (o1_tvalid),
      .o1_tready  (o1_tready),
      .en         (en),
      .busy       (busy),
      .err_timeout(err_timeout),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past a rising edge; inputs are then changed away from the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; i_tdata = 8'h00; i_tvalid = 1'b0; en = 2'b00;
      o0_tready = 1'b0; o1_tready = 1'b0; clr_err = 1'b0;
      settle();
      check("rst_itready", 8'(i_tready), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_valids", {6'b0, o1_tvalid, o0_tvalid}, 8'h0);
      tick(); tick();
      check("rst_err", 8'(err_timeout), 8'h0);
      check("rst_itready_held", 8'(i_tready), 8'h0);
      rst = 1'b0;
      settle();
      check("post_rst_itready", 8'(i_tready), 8'h1);

      // Broadcast to both sinks, both ready
      en = 2'b11; o0_tready = 1'b1; o1_tready = 1'b1; i_tdata = 8'hA5; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      settle();
      check("bc_valids", {6'b0, o1_tvalid, o0_tvalid}, 8'h3);
      check("bc_o0_data", o0_tdata, 8'hA5);
      check("bc_o1_data", o1_tdata, 8'hA5);
      check("bc_busy", 8'(busy), 8'h1);
      check("bc_itready", 8'(i_tready), 8'h0);
      tick();
      settle();
      check("bc_idle_busy", 8'(busy), 8'h0);
      check("bc_idle_itready", 8'(i_tready), 8'h1);
      check("bc_idle_valids", {6'b0, o1_tvalid, o0_tvalid}, 8'h0);

      // Sink 1 stalls 5 cycles; en and upstream change meanwhile
      o1_tready = 1'b0; i_tdata = 8'hA5; i_tvalid = 1'b1; en = 2'b11;
      tick();
      i_tdata = 8'h5A; en = 2'b10;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("stall_o0_valid_%0d", k), 8'(o0_tvalid), (k == 0) ? 8'h1 : 8'h0);
         check($sformatf("stall_o1_valid_%0d", k), 8'(o1_tvalid), 8'h1);
         check($sformatf("stall_o1_data_%0d", k), o1_tdata, 8'hA5);
         check($sformatf("stall_busy_%0d", k), 8'(busy), 8'h1);
         check($sformatf("stall_itready_%0d", k), 8'(i_tready), 8'h0);
         if (k == 4) o1_tready = 1'b1;
         tick();
      end
      settle();
      check("stall_done_busy", 8'(busy), 8'h0);
      check("stall_done_itready", 8'(i_tready), 8'h1);
      tick();
      i_tvalid = 1'b0;
      settle();
      check("next_o1_valid", 8'(o1_tvalid), 8'h1);
      check("next_o0_valid", 8'(o0_tvalid), 8'h0);
      check("next_o1_data", o1_tdata, 8'h5A);
      tick();
      settle();
      check("next_done_busy", 8'(busy), 8'h0);

      // Single-sink send, then a dropped byte with no sinks enabled
      en = 2'b01; i_tdata = 8'h3C; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      settle();
      check("only0_o0_valid", 8'(o0_tvalid), 8'h1);
      check("only0_o1_valid", 8'(o1_tvalid), 8'h0);
      check("only0_data", o0_tdata, 8'h3C);
      tick();
      en = 2'b00; i_tdata = 8'h77; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      settle();
      check("drop_valids", {6'b0, o1_tvalid, o0_tvalid}, 8'h0);
      check("drop_busy", 8'(busy), 8'h0);
      check("drop_itready", 8'(i_tready), 8'h1);

      // Sink 1 stuck low
      o1_tready = 1'b0; en = 2'b11; i_tdata = 8'h11; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
`ifdef FANOUT_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         settle();
         check($sformatf("to_o1_valid_%0d", k), 8'(o1_tvalid), 8'h1);
         check($sformatf("to_err_%0d", k), 8'(err_timeout), 8'h0);
         tick();
      end
      settle();
      check("to_o1_fall", 8'(o1_tvalid), 8'h0);
      check("to_busy", 8'(busy), 8'h0);
      check("to_err_set", 8'(err_timeout), 8'h2);
      tick(); tick();
      check("to_err_sticky", 8'(err_timeout), 8'h2);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("to_err_clr", 8'(err_timeout), 8'h0);

      // Sink 1 completes on the expiry cycle
      i_tdata = 8'h22; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k == 15) o1_tready = 1'b1;
         tick();
      end
      settle();
      check("to_late_err", 8'(err_timeout), 8'h0);
      check("to_late_busy", 8'(busy), 8'h0);

      // Expiry coinciding with clr_err keeps the flag
      o1_tready = 1'b0; i_tdata = 8'h33; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         clr_err = (k == 15);
         tick();
      end
      clr_err = 1'b0;
      settle();
      check("to_set_vs_clr", 8'(err_timeout), 8'h2);
`else
      for (int k = 0; k < 20; k++) begin
         settle();
         check($sformatf("wait_o1_valid_%0d", k), 8'(o1_tvalid), 8'h1);
         check($sformatf("wait_err_%0d", k), 8'(err_timeout), 8'h0);
         tick();
      end
      o1_tready = 1'b1;
      tick();
      settle();
      check("wait_done_busy", 8'(busy), 8'h0);
      o1_tready = 1'b0;
`endif

      // Reset pulse in the middle of a broadcast
      en = 2'b10; i_tdata = 8'h44; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      settle();
      check("mid_busy", 8'(busy), 8'h1);
      rst = 1'b1;
      settle();
      check("mid_rst_itready", 8'(i_tready), 8'h0);
      tick();
      check("mid_rst_valids", {6'b0, o1_tvalid, o0_tvalid}, 8'h0);
      check("mid_rst_busy", 8'(busy), 8'h0);
      check("mid_rst_err", 8'(err_timeout), 8'h0);
      check("mid_rst_itready_edge", 8'(i_tready), 8'h0);
      rst = 1'b0;
      settle();
      check("mid_post_itready", 8'(i_tready), 8'h1);
      check("mid_post_o1_valid", 8'(o1_tvalid), 8'h0);
      en = 2'b01; i_tdata = 8'h99; i_tvalid = 1'b1;
      tick();
      i_tvalid = 1'b0;
      settle();
      check("mid_first_o0_valid", 8'(o0_tvalid), 8'h1);
      check("mid_first_o0_data", o0_tdata, 8'h99);
      check("mid_first_err", 8'(err_timeout), 8'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
